mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
//   Shares the core's single memory port between instruction fetch (I) and the load/store unit (D).
//   Arbitrates, latches the winning request, drives it to memory and routes the response back.
//   One transaction outstanding at a time; sits between the pipeline front/back end and memory inside top.
//   D has priority; a starvation guard forces an I grant after STARVE_LIMIT consecutive contested D grants.
// PARAMETERS
//   ADDR_W        32  address width
//   DATA_W        32  data width (wstrb width = DATA_W/8)
//   STARVE_LIMIT  4   contested D grants before I is forced; 0 = I wins every conflict
// PORTS
//   clock         in   1         core clock, all logic on rising edge
//   reset         in   1         synchronous, active-high
//   flush         in   1         pipeline redirect: drop in-flight/pending fetch
//   i_req_valid   in   1         fetch request
//   i_req_ready   out  1         fetch request accepted this cycle
//   i_req_addr    in   ADDR_W    fetch address
//   i_resp_valid  out  1         fetch data valid (1 cycle)
//   i_resp_data   out  DATA_W    fetch data
//   d_req_valid   in   1         load/store request
//   d_req_ready   out  1         load/store accepted this cycle
//   d_req_addr    in   ADDR_W    load/store address
//   d_req_wen     in   1         1 = store
//   d_req_wdata   in   DATA_W    store data
//   d_req_wstrb   in   DATA_W/8  byte enables
//   d_resp_valid  out  1         load data / store ack valid (1 cycle)
//   d_resp_data   out  DATA_W    load data
//   m_req_valid   out  1         memory request
//   m_req_ready   in   1         memory accepts request
//   m_req_addr    out  ADDR_W    latched address
//   m_req_wen     out  1         latched write enable (0 for I)
//   m_req_wdata   out  DATA_W    latched write data (0 for I)
//   m_req_wstrb   out  DATA_W/8  latched strobes (0 for I)
//   m_resp_valid  in   1         memory response (reads and write acks)
//   m_resp_data   in   DATA_W    memory read data
//   busy          out  1         state != IDLE
// BEHAVIOUR
//   FSM: IDLE -> REQ -> WAIT -> IDLE. Registers: state, owner (I/D), drop, starve_cnt, latched req fields.
//   IDLE: grant combinational; i/d_req_ready high only in IDLE for the winner, same cycle as its valid.
//     D only -> D. I only (flush=0) -> I. Both -> I if starve_cnt >= STARVE_LIMIT, else D.
//     flush=1 blocks an I grant that cycle (i_req_ready=0); D unaffected.
//     On grant: latch fields, set owner, drop=0, go REQ. No grant: stay IDLE.
//   starve_cnt: +1 (saturating) on D grant while i_req_valid=1; cleared on I grant; else held.
//   REQ: m_req_valid=1, fields held stable until m_req_ready=1 -> WAIT. Not revocable.
//   WAIT: on m_resp_valid=1 -> IDLE; owner's resp_valid = m_resp_valid, resp_data = m_resp_data
//     (combinational pass-through, zero added latency); other requester's resp_valid=0.
//   m_resp_valid in IDLE or REQ is ignored (no output, no state change).
//   flush while owner=I in REQ/WAIT sets drop=1; transaction completes, i_resp_valid suppressed.
//   Simultaneous flush and response in WAIT: response suppressed. flush never affects D.
//   Latency: accept at T, m_req_valid at T+1; earliest resp at T+2; next grant earliest T+3.
//   Reset (any state, incl. mid-transaction): state IDLE, all outputs 0, starve_cnt 0, drop 0,
//     latched fields 0; abandoned transaction's late response dropped as stray IDLE response.
//   resp_data outputs 0 whenever the matching resp_valid is 0.
// TESTING
//   Fetch 0x80000000, m_req_ready=1, resp 0x00000013 next cycle -> i_req_ready@T0, m_req_valid@T1 addr 0x80000000, i_resp_valid+0x00000013@T2, busy 0@T3.
//   I and D valid every cycle, LIMIT=4 -> grants D,D,D,D,I,D,D,D,D,I...; starve_cnt 0 after each I grant.
//   Store 0xDEADBEEF wstrb 0xF @0x1000, m_req_ready low 3 cycles -> m_req_* stable 4 cycles, m_req_wen=1, ready low for both requesters, d_resp_valid on ack.
//   Fetch in WAIT, flush pulse, resp 0xCAFEF00D -> i_resp_valid stays 0, IDLE next cycle, next fetch granted.
//   Reset in WAIT, then stray m_resp_valid -> all outputs 0 after reset, stray ignored, next D load returns data normally.
//   LIMIT=0, I and D both valid -> I granted; D granted next IDLE cycle if I idle.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle for the memory port arbiter: fetch side, load/store side,
// memory side, plus the pipeline flush input and the busy status.
// slave  = the arbiter's view, master = the surrounding core / memory view.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int STRB_W = DATA_W / 8;

  logic              flush;
  // instruction fetch
  logic              i_req_valid;
  logic              i_req_ready;
  logic [ADDR_W-1:0] i_req_addr;
  logic              i_resp_valid;
  logic [DATA_W-1:0] i_resp_data;
  // load/store
  logic              d_req_valid;
  logic              d_req_ready;
  logic [ADDR_W-1:0] d_req_addr;
  logic              d_req_wen;
  logic [DATA_W-1:0] d_req_wdata;
  logic [STRB_W-1:0] d_req_wstrb;
  logic              d_resp_valid;
  logic [DATA_W-1:0] d_resp_data;
  // memory
  logic              m_req_valid;
  logic              m_req_ready;
  logic [ADDR_W-1:0] m_req_addr;
  logic              m_req_wen;
  logic [DATA_W-1:0] m_req_wdata;
  logic [STRB_W-1:0] m_req_wstrb;
  logic              m_resp_valid;
  logic [DATA_W-1:0] m_resp_data;
  logic              busy;

  modport slave (
    input  flush,
    input  i_req_valid, i_req_addr,
    output i_req_ready, i_resp_valid, i_resp_data,
    input  d_req_valid, d_req_addr, d_req_wen, d_req_wdata, d_req_wstrb,
    output d_req_ready, d_resp_valid, d_resp_data,
    output m_req_valid, m_req_addr, m_req_wen, m_req_wdata, m_req_wstrb,
    input  m_req_ready, m_resp_valid, m_resp_data,
    output busy
  );

  modport master (
    output flush,
    output i_req_valid, i_req_addr,
    input  i_req_ready, i_resp_valid, i_resp_data,
    output d_req_valid, d_req_addr, d_req_wen, d_req_wdata, d_req_wstrb,
    input  d_req_ready, d_resp_valid, d_resp_data,
    input  m_req_valid, m_req_addr, m_req_wen, m_req_wdata, m_req_wstrb,
    output m_req_ready, m_resp_valid, m_resp_data,
    input  busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch (I) and load/store (D).
// One transaction in flight: IDLE grants, REQ presents the latched request
// until memory takes it, WAIT routes the single-cycle response to its owner.
// D wins conflicts unless I has lost STARVE_LIMIT contested grants in a row.
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  mem_port_arbiter_if.slave    bus
);
  localparam int STRB_W = DATA_W / 8;
  // Counter can exceed STARVE_LIMIT by at least one, so saturation never
  // hides the limit (also valid for STARVE_LIMIT = 0).
  localparam int CNT_W  = $clog2(STARVE_LIMIT + 2);
  localparam int CW1    = CNT_W + 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              wen;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
  } req_t;

  logic [1:0]       state;
  logic             owner_d;   // 1 = current/last transaction belongs to D
  logic             drop;      // fetch was flushed, swallow its response
  logic [CNT_W-1:0] starve_cnt;
  req_t             lat;

  logic             in_idle;
  logic             limit_hit;
  logic             grant_i;
  logic             grant_d;
  logic             resp_win;
  logic [CW1-1:0]   cnt_ext;

  // Grant decision; only meaningful in IDLE and never while reset is held.
  always_comb begin
    in_idle   = (state == IDLE) && !reset;
    cnt_ext   = {1'b0, starve_cnt};
    // starve_cnt >= STARVE_LIMIT, written so it stays non-trivial at limit 0
    limit_hit = (cnt_ext + CW1'(1)) > CW1'(STARVE_LIMIT);
    grant_i   = in_idle && bus.i_req_valid && !bus.flush &&
                (!bus.d_req_valid || limit_hit);
    grant_d   = in_idle && bus.d_req_valid && !grant_i;
  end

  // Response routing is a pure pass-through of the memory response in WAIT.
  always_comb begin
    resp_win         = !reset && (state == WAIT) && bus.m_resp_valid;
    bus.i_req_ready  = grant_i;
    bus.d_req_ready  = grant_d;
    bus.i_resp_valid = resp_win && !owner_d && !drop && !bus.flush;
    bus.i_resp_data  = bus.i_resp_valid ? bus.m_resp_data : '0;
    bus.d_resp_valid = resp_win && owner_d;
    bus.d_resp_data  = bus.d_resp_valid ? bus.m_resp_data : '0;
    bus.m_req_valid  = !reset && (state == REQ);
    bus.m_req_addr   = lat.addr;
    bus.m_req_wen    = lat.wen;
    bus.m_req_wdata  = lat.wdata;
    bus.m_req_wstrb  = lat.wstrb;
    bus.busy         = !reset && (state != IDLE);
  end

  // Transaction FSM: latch on grant, hold through REQ, retire on response.
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      owner_d <= 1'b0;
      drop    <= 1'b0;
      lat     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_d) begin
            state   <= REQ;
            owner_d <= 1'b1;
            drop    <= 1'b0;
            lat     <= '{addr: bus.d_req_addr, wen: bus.d_req_wen,
                         wdata: bus.d_req_wdata, wstrb: bus.d_req_wstrb};
          end else if (grant_i) begin
            state   <= REQ;
            owner_d <= 1'b0;
            drop    <= 1'b0;
            // fetches are reads: write fields forced to zero
            lat     <= '{addr: bus.i_req_addr, wen: 1'b0,
                         wdata: '0, wstrb: '0};
          end
        end
        REQ: begin
          // a fetch already handed off cannot be revoked, only muted
          if (bus.flush && !owner_d) drop <= 1'b1;
          if (bus.m_req_ready) state <= WAIT;
        end
        WAIT: begin
          if (bus.flush && !owner_d) drop <= 1'b1;
          if (bus.m_resp_valid) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Starvation counter: counts D wins while I was waiting, cleared by I wins.
  always_ff @(posedge clock) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (grant_i) begin
      starve_cnt <= '0;
    end else if (grant_d && bus.i_req_valid && (starve_cnt != '1)) begin
      starve_cnt <= starve_cnt + CNT_W'(1);
    end
  end
endmodule
